l2_bank_rr_arbiter: RTL and testbench
=====================================

Name: l2_bank_rr_arbiter

Overview:
- Shares one 32-bit TCDM slave port, e.g. one L2 private bank or the boot ROM, between NR_MASTERS TCDM requesters.
- Uses round-robin arbitration and tracks outstanding reads and writes in an index FIFO, so each r_valid is returned to the master that issued it.
- Sits between contiguous-crossbar outputs and a memory macro, or in front of an accelerator slave port.
- Slave response latency may be variable, but responses return in order.

Parameters:
NR_MASTERS, 4, number of requesting TCDM masters (2..16)
ADDR_WIDTH, 32, TCDM address width
DATA_WIDTH, 32, TCDM data width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 2, depth of the outstanding-index FIFO (1..8)

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
mst_req_i  in  NR_MASTERS  per-master request
mst_add_i  in  NR_MASTERS*ADDR_WIDTH  per-master address
mst_wen_i  in  NR_MASTERS  per-master write-enable, active-low (1 = read)
mst_wdata_i  in  NR_MASTERS*DATA_WIDTH  per-master write data
mst_be_i  in  NR_MASTERS*DATA_WIDTH/8  per-master byte enables
mst_gnt_o  out  NR_MASTERS  per-master grant
mst_r_valid_o  out  NR_MASTERS  per-master response valid
mst_r_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters
slv_req_o  out  1  request to slave
slv_add_o  out  ADDR_WIDTH  address to slave
slv_wen_o  out  1  write-enable to slave
slv_wdata_o  out  DATA_WIDTH  write data to slave
slv_be_o  out  DATA_WIDTH/8  byte enables to slave
slv_gnt_i  in  1  slave grant
slv_r_valid_i  in  1  slave response valid
slv_r_rdata_i  in  DATA_WIDTH  slave read data
rsp_err_o  out  1  sticky flag: slave sent a response with no outstanding request

Behaviour:
- Reset (rst_i=1 at a rising clk_i edge):
  - Round-robin pointer goes to 0.
  - Index FIFO is emptied.
  - rsp_err_o is cleared.
  - All mst_r_valid_o are 0 in the cycle after reset.
- Arbitration is combinational:
  - sel = first index i, searching upward from the pointer with wrap-around, where mst_req_i[i]=1.
  - sel is valid only if any mst_req_i is set.
- Request forwarding:
  - slv_req_o = any_req & ~fifo_full.
  - slv_add_o, slv_wen_o, slv_wdata_o and slv_be_o are muxed from master sel.
  - These outputs are 0 when no request is forwarded.
- Grant:
  - mst_gnt_o[sel] = slv_gnt_i & slv_req_o.
  - All other bits of mst_gnt_o are 0.
  - There is no combinational path from slv_r_valid_i to slv_req_o.
- Handshake completes when slv_req_o & slv_gnt_i:
  - sel is pushed into the FIFO.
  - The pointer becomes (sel+1) mod NR_MASTERS on the next edge.
  - Without a handshake the pointer holds.
  - A master dropping req before grant is legal; re-arbitration occurs in the same cycle.
- Full FIFO:
  - When fifo_full, slv_req_o=0.
  - Push and pop in the same cycle are allowed only when not full.
  - A pop while full frees a slot for the next cycle.
- Response routing:
  - When slv_r_valid_i=1 and the FIFO is non-empty: mst_r_valid_o[head]=1 combinationally, then the FIFO pops.
  - mst_r_rdata_o = slv_r_rdata_i, unconditionally.
- Response with empty FIFO:
  - slv_r_valid_i=1 with an empty FIFO drives no mst_r_valid_o.
  - rsp_err_o goes to 1 on the next edge and stays there until reset.
- Push and pop on the same cycle: occupancy is unchanged, and the pushed index is ordered behind the head.
- Reset mid-operation: outstanding responses are discarded; the slave is expected to be reset together with the arbiter.
- Master-facing latency equals the slave latency; the arbiter adds no extra cycles.

Optional Feature:
- Macro: L2_BANK_ARB_PERF_CNT_EN.
- When defined, adds two 32-bit output ports, both reset to 0 and both saturating at 32'hFFFF_FFFF:
  - perf_conflict_cnt_o: increments in each cycle where more than one mst_req_i is high and a handshake occurs.
  - perf_stall_cnt_o: increments in each cycle where any_req & fifo_full.
- When undefined, these ports and their counters do not exist.

Decomposition:
- Package l2_bank_arb_pkg contains:
  - function clog2_min1(n), returning max(1, $clog2(n));
  - typedef perf_cnt_t = logic[31:0];
  - constant PERF_CNT_MAX.
- Sub-module l2_bank_arb_idx_fifo: synchronous FIFO of clog2_min1(NR_MASTERS)-bit indices.
  - Parameter DEPTH.
  - Ports push/pop/full/empty/head.
  - Synchronous active-high reset.

Test Plan:
- Round-robin fairness: NR_MASTERS=4, all four masters request continuously, slave gnt=1, response latency 1.
  - Grants cycle 0,1,2,3,0.
  - Each r_valid arrives at the master granted one cycle earlier.
- Full FIFO: MAX_OUTSTANDING=2, slave grants but withholds r_valid.
  - After 2 handshakes, slv_req_o=0.
  - One r_valid then re-enables the request the following cycle.
- Variable latency: responses at latencies 3 and 1 with back-to-back grants to masters 2 and 0.
  - r_valid is routed to master 2 first, then master 0, in order.
  - The rdata values 32'hDEAD_BEEF and 32'h1234_5678 are delivered correctly.
- Spurious response: slv_r_valid_i=1 with an empty FIFO.
  - No mst_r_valid_o is raised.
  - rsp_err_o=1 from the next cycle and persists until rst_i.
- Reset mid-operation: rst_i asserted with 2 responses outstanding.
  - The FIFO empties and the pointer returns to 0.
  - The first grant after reset goes to master 0 when masters 0 and 3 both request.
- Perf counters (L2_BANK_ARB_PERF_CNT_EN): run 10 cycles with 2 masters requesting and the slave granting.
  - perf_conflict_cnt_o=10.

Source files
------------

// File: rtl/l2_bank_arb_pkg.sv
// l2_bank_arb_pkg
//   Shared types, constants and helpers for the L2 bank round-robin arbiter.
//   clog2_min1(n) : max(1, $clog2(n)); keeps index vectors at least 1 bit wide.
//   perf_cnt_t    : 32-bit performance counter type.
//   PERF_CNT_MAX  : saturation value of the performance counters.
package l2_bank_arb_pkg;

   typedef logic [31:0] perf_cnt_t;

   localparam perf_cnt_t PERF_CNT_MAX = 32'hFFFF_FFFF;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/l2_bank_arb_idx_fifo.sv
// l2_bank_arb_idx_fifo
//   Synchronous FIFO holding the master index of every outstanding slave
//   transaction, so in-order responses can be routed back.
//   Ports:
//     clk   in   clock
//     rst   in   synchronous active-high reset (empties the FIFO)
//     push  in   write din (ignored when full)
//     din   in   master index to store
//     pop   in   drop the head entry (ignored when empty)
//     full  out  DEPTH entries stored
//     empty out  no entries stored
//     head  out  oldest stored index
module l2_bank_arb_idx_fifo
   import l2_bank_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // storage needs no reset: entries are only read while counted valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// l2_bank_rr_arbiter
//   Shares one 32-bit TCDM slave port between NR_MASTERS requesters with
//   round-robin arbitration. Master indices of outstanding transactions are
//   kept in an index FIFO so in-order slave responses reach their issuer.
//   Optional macro L2_BANK_ARB_PERF_CNT_EN adds conflict/stall counters.
//   Ports:
//     clk_i, rst_i                clock, synchronous active-high reset
//     mst_req_i/add/wen/wdata/be  per-master request bundle (flat vectors)
//     mst_gnt_o                   per-master grant
//     mst_r_valid_o               per-master response valid
//     mst_r_rdata_o               response data broadcast to all masters
//     slv_req/add/wen/wdata/be_o  forwarded request to the slave
//     slv_gnt_i, slv_r_valid_i, slv_r_rdata_i  slave handshake / response
//     rsp_err_o                   sticky: response seen with nothing outstanding
//     perf_conflict_cnt_o         (macro) handshakes with >1 requester
//     perf_stall_cnt_o            (macro) cycles blocked by a full FIFO
module l2_bank_rr_arbiter
   import l2_bank_arb_pkg::*;
#(
   parameter int NR_MASTERS      = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NR_MASTERS-1:0]            mst_req_i,
   input  logic [NR_MASTERS*ADDR_WIDTH-1:0] mst_add_i,
   input  logic [NR_MASTERS-1:0]            mst_wen_i,
   input  logic [NR_MASTERS*DATA_WIDTH-1:0] mst_wdata_i,
   input  logic [NR_MASTERS*DATA_WIDTH/8-1:0] mst_be_i,
   output logic [NR_MASTERS-1:0]            mst_gnt_o,
   output logic [NR_MASTERS-1:0]            mst_r_valid_o,
   output logic [DATA_WIDTH-1:0]            mst_r_rdata_o,
   output logic                             slv_req_o,
   output logic [ADDR_WIDTH-1:0]            slv_add_o,
   output logic                             slv_wen_o,
   output logic [DATA_WIDTH-1:0]            slv_wdata_o,
   output logic [DATA_WIDTH/8-1:0]          slv_be_o,
   input  logic                             slv_gnt_i,
   input  logic                             slv_r_valid_i,
   input  logic [DATA_WIDTH-1:0]            slv_r_rdata_i,
   output logic                             rsp_err_o
`ifdef L2_BANK_ARB_PERF_CNT_EN
   ,
   output logic [31:0]                      perf_conflict_cnt_o,
   output logic [31:0]                      perf_stall_cnt_o
`endif
);

   localparam int IDX_W = clog2_min1(NR_MASTERS);
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_MASTERS - 1);

   // per-master views of the flat request buses
   logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] add;
   logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] wdata;
   logic [NR_MASTERS-1:0][BE_W-1:0]       be;

   assign add   = mst_add_i;
   assign wdata = mst_wdata_i;
   assign be    = mst_be_i;

   logic [IDX_W-1:0] ptr, sel, head;
   logic             any_req, full, empty, fwd, hs, rsp_pop;

   assign any_req = |mst_req_i;

   // first requester at or above ptr, wrapping; ptr < NR_MASTERS always
   always_comb begin
      int  j;
      logic found;
      sel   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NR_MASTERS; k++) begin
         j = int'(ptr) + k;
         if (j >= NR_MASTERS) j = j - NR_MASTERS;
         if (!found && mst_req_i[j]) begin
            sel   = IDX_W'(j);
            found = 1'b1;
         end
      end
   end

   // request gating depends only on FIFO state, never on slv_r_valid_i
   assign fwd = any_req & ~full;
   assign hs  = fwd & slv_gnt_i;

   assign slv_req_o   = fwd;
   assign slv_add_o   = fwd ? add[sel]          : '0;
   assign slv_wen_o   = fwd ? mst_wen_i[sel]    : 1'b0;
   assign slv_wdata_o = fwd ? wdata[sel]        : '0;
   assign slv_be_o    = fwd ? be[sel]           : '0;

   always_comb begin
      mst_gnt_o = '0;
      if (hs) mst_gnt_o[sel] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)   ptr <= '0;
      else if (hs) ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
   end

   // response routing: responses are in order, so the FIFO head owns it
   assign rsp_pop       = slv_r_valid_i & ~empty;
   assign mst_r_rdata_o = slv_r_rdata_i;

   always_comb begin
      mst_r_valid_o = '0;
      if (rsp_pop) mst_r_valid_o[head] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                      rsp_err_o <= 1'b0;
      else if (slv_r_valid_i & empty) rsp_err_o <= 1'b1;
   end

   l2_bank_arb_idx_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W)
   ) u_idx_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (hs),
      .din   (sel),
      .pop   (rsp_pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

`ifdef L2_BANK_ARB_PERF_CNT_EN
   logic multi_req;

   // more than one bit set <=> clearing the lowest set bit leaves something
   assign multi_req = |(mst_req_i & (mst_req_i - 1'b1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_conflict_cnt_o <= '0;
         perf_stall_cnt_o    <= '0;
      end else begin
         if (multi_req && hs && perf_conflict_cnt_o != PERF_CNT_MAX)
            perf_conflict_cnt_o <= perf_conflict_cnt_o + 1'b1;
         if (any_req && full && perf_stall_cnt_o != PERF_CNT_MAX)
            perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// tb_l2_bank_rr_arbiter
//   Directed scenarios plus randomized traffic against a queue-based model of
//   the arbiter and an in-order slave with random latency. Expected responses
//   go into a scoreboard queue that a separate monitor drains.
module tb_l2_bank_rr_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     mst_req_i = '0;
   logic [NR*AW-1:0]  mst_add_i = '0;
   logic [NR-1:0]     mst_wen_i = '0;
   logic [NR*DW-1:0]  mst_wdata_i = '0;
   logic [NR*BW-1:0]  mst_be_i = '0;
   logic [NR-1:0]     mst_gnt_o;
   logic [NR-1:0]     mst_r_valid_o;
   logic [DW-1:0]     mst_r_rdata_o;
   logic              slv_req_o;
   logic [AW-1:0]     slv_add_o;
   logic              slv_wen_o;
   logic [DW-1:0]     slv_wdata_o;
   logic [BW-1:0]     slv_be_o;
   logic              slv_gnt_i = 1'b0;
   logic              slv_r_valid_i = 1'b0;
   logic [DW-1:0]     slv_r_rdata_i = '0;
   logic              rsp_err_o;
`ifdef L2_BANK_ARB_PERF_CNT_EN
   logic [31:0]       perf_conflict_cnt_o;
   logic [31:0]       perf_stall_cnt_o;
`endif

   always #5 clk = ~clk;

   l2_bank_rr_arbiter #(
      .NR_MASTERS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .mst_req_i(mst_req_i), .mst_add_i(mst_add_i), .mst_wen_i(mst_wen_i),
      .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i),
      .mst_gnt_o(mst_gnt_o), .mst_r_valid_o(mst_r_valid_o),
      .mst_r_rdata_o(mst_r_rdata_o),
      .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
      .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o),
      .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i),
      .slv_r_rdata_i(slv_r_rdata_i), .rsp_err_o(rsp_err_o)
`ifdef L2_BANK_ARB_PERF_CNT_EN
      , .perf_conflict_cnt_o(perf_conflict_cnt_o),
      .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
   );

   typedef struct { int idx; logic [DW-1:0] data; } exp_t;
   typedef struct { int due; logic [DW-1:0] data; } rsp_t;

   exp_t exp_q[$];     // scoreboard: expected master responses in order
   rsp_t slv_q[$];     // slave model: pending responses with due cycle

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_ptr = 0;      // model round-robin pointer
   int m_cnt = 0;      // model outstanding count
   bit m_err = 1'b0;   // model sticky error
   int last_due = 0;

   logic [AW-1:0] add_a [NR];
   logic [DW-1:0] wd_a  [NR];
   logic [BW-1:0] be_a  [NR];
   logic          wen_a [NR];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // one clock cycle: drive after the edge, check on the falling edge, advance model
   task automatic do_cycle(input bit r, input logic [NR-1:0] req, input bit gnt,
                           input bit spur, input int lat, input logic [DW-1:0] rdat);
      int  sel;
      bit  fwd, rv;
      int  due;
      logic [DW-1:0] rsp_data;
      @(posedge clk); #1;
      cyc++;
      rst = r;
      mst_req_i = req;
      for (int i = 0; i < NR; i++) begin
         add_a[i] = $urandom;
         wd_a[i]  = $urandom;
         be_a[i]  = BW'($urandom);
         wen_a[i] = 1'($urandom);
         mst_add_i[i*AW +: AW]   = add_a[i];
         mst_wdata_i[i*DW +: DW] = wd_a[i];
         mst_be_i[i*BW +: BW]    = be_a[i];
         mst_wen_i[i]            = wen_a[i];
      end
      slv_gnt_i = gnt;
      rv = 1'b0;
      rsp_data = $urandom;
      if (!r && slv_q.size() > 0 && slv_q[0].due <= cyc) begin
         rv = 1'b1;
         rsp_data = slv_q[0].data;
      end else if (!r && spur && m_cnt == 0) begin
         rv = 1'b1;
      end
      slv_r_valid_i = rv;
      slv_r_rdata_i = rsp_data;
      @(negedge clk);
      if (r) begin
         m_ptr = 0; m_cnt = 0; m_err = 1'b0; last_due = cyc;
         exp_q.delete();
         slv_q.delete();
         return;
      end
      sel = -1;
      for (int k = 0; k < NR; k++)
         if (sel < 0 && req[(m_ptr + k) % NR]) sel = (m_ptr + k) % NR;
      fwd = (sel >= 0) && (m_cnt < MO);
      chk("slv_req", slv_req_o, fwd);
      chk("mst_gnt", mst_gnt_o, (fwd && gnt) ? (64'd1 << sel) : 64'd0);
      chk("slv_add",   slv_add_o,   fwd ? add_a[sel] : '0);
      chk("slv_wen",   slv_wen_o,   fwd ? wen_a[sel] : 1'b0);
      chk("slv_wdata", slv_wdata_o, fwd ? wd_a[sel]  : '0);
      chk("slv_be",    slv_be_o,    fwd ? be_a[sel]  : '0);
      chk("rvalid_any", |mst_r_valid_o, rv && (m_cnt > 0));
      chk("rsp_err", rsp_err_o, m_err);
      if (rv) begin
         if (m_cnt > 0) begin
            m_cnt--;
            void'(slv_q.pop_front());
         end else m_err = 1'b1;
      end
      if (fwd && gnt) begin
         m_cnt++;
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         slv_q.push_back('{due, rdat});
         exp_q.push_back('{sel, rdat});
         m_ptr = (sel + 1) % NR;
      end
   endtask

   // monitor: every raised r_valid consumes the oldest expected response
   always @(negedge clk) begin
      if (rst === 1'b0 && (|mst_r_valid_o)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected (cycle %0d): got %0h expected none", cyc, mst_r_valid_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rvalid_idx", mst_r_valid_o, 64'd1 << e.idx);
            chk("rdata", mst_r_rdata_o, e.data);
         end
      end
   end

   initial begin
      // reset and idle
      do_cycle(1, '0, 0, 0, 1, '0);
      do_cycle(1, '0, 0, 0, 1, '0);
      do_cycle(0, '0, 0, 0, 1, '0);
      chk("reset_rsp_err", rsp_err_o, 1'b0);

      // fairness: all request, grant always, latency 1
      for (int i = 0; i < 9; i++) do_cycle(0, 4'hF, 1, 0, 1, $urandom);
      for (int i = 0; i < 3; i++) do_cycle(0, '0, 0, 0, 1, '0);

      // full FIFO: long latency, requests stall after MO handshakes
      for (int i = 0; i < 10; i++) do_cycle(0, 4'hF, 1, 0, 6, $urandom);
      for (int i = 0; i < 12; i++) do_cycle(0, '0, 0, 0, 1, '0);

      // variable latency: master 2 (lat 3) then master 0 (lat 1)
      do_cycle(1, '0, 0, 0, 1, '0);
      do_cycle(0, 4'b0100, 1, 0, 3, 32'hDEAD_BEEF);
      do_cycle(0, 4'b0001, 1, 0, 1, 32'h1234_5678);
      for (int i = 0; i < 6; i++) do_cycle(0, '0, 0, 0, 1, '0);

      // spurious response, error sticks until reset
      do_cycle(0, '0, 0, 1, 1, '0);
      for (int i = 0; i < 4; i++) do_cycle(0, 4'b0010, 1, 0, 1, $urandom);
      chk("rsp_err_sticky", rsp_err_o, 1'b1);

      // reset mid-operation with two outstanding
      do_cycle(0, 4'hF, 1, 0, 8, $urandom);
      do_cycle(0, 4'hF, 1, 0, 8, $urandom);
      do_cycle(1, '0, 0, 0, 1, '0);
      do_cycle(0, 4'b1001, 1, 0, 1, $urandom);
      chk("post_reset_gnt0", mst_gnt_o, 4'b0001);
      for (int i = 0; i < 4; i++) do_cycle(0, '0, 0, 0, 1, '0);

`ifdef L2_BANK_ARB_PERF_CNT_EN
      do_cycle(1, '0, 0, 0, 1, '0);
      for (int i = 0; i < 10; i++) do_cycle(0, 4'b0011, 1, 0, 1, $urandom);
      @(posedge clk); #1;
      chk("perf_conflict", perf_conflict_cnt_o, 32'd10);
      chk("perf_stall", perf_stall_cnt_o, 32'd0);
      do_cycle(0, '0, 0, 0, 1, '0);
      do_cycle(0, '0, 0, 0, 1, '0);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         do_cycle(($urandom_range(0, 299) == 0),
                  NR'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) == 0),
                  $urandom_range(1, 5),
                  $urandom);
      end

      // drain
      for (int i = 0; i < 20; i++) do_cycle(0, '0, 0, 0, 1, '0);
      chk("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
